// File: rtl/ysyx_23060111_ifu_hs.sv
// Multi-cycle instruction fetch unit: owns the PC, fetches one word per
// instruction over a valid/ready read channel and hands it to the IDU.
module ysyx_23060111_ifu_hs #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc,
  output logic              mem_arvalid,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              mem_rready,
  output logic              inst_valid,
  output logic [31:0]       inst,
  input  logic              inst_ready,
  input  logic              npc_valid,
  input  logic [ADDR_W-1:0] npc,
  output logic              fetch_err,
  output logic [1:0]        err_cause
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_WNPC = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [1:0] CAUSE_BUS   = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [31:0]       inst_reg, inst_next;
  logic              err_reg, err_next;
  logic [1:0]        cause_reg, cause_next;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    err_next   = err_reg;
    cause_next = cause_reg;
    case (state_reg)
      S_IDLE: state_next = S_AR;
      S_AR: begin
        if (mem_arready) state_next = S_R;
      end
      S_R: begin
        if (mem_rvalid) begin
          if (mem_rresp == 2'b00) begin
            inst_next  = mem_rdata;
            state_next = S_OUT;
          end else begin
            err_next   = 1'b1;
            cause_next = CAUSE_BUS;
            state_next = S_ERR;
          end
        end
      end
      S_OUT: begin
        if (inst_ready) state_next = S_WNPC;
      end
      S_WNPC: begin
        if (npc_valid) begin
          if (npc[1:0] == 2'b00) begin
            pc_next    = npc;
            state_next = S_AR;
          end else begin
            err_next   = 1'b1;
            cause_next = CAUSE_ALIGN;
            state_next = S_ERR;
          end
        end
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
    // Only the first fault is ever recorded.
    if (err_reg) begin
      err_next   = err_reg;
      cause_next = cause_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'h0;
      err_reg   <= 1'b0;
      cause_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      err_reg   <= err_next;
      cause_reg <= cause_next;
    end
  end

  assign pc          = pc_reg;
  assign mem_araddr  = pc_reg;
  assign mem_arvalid = (state_reg == S_AR);
  assign mem_rready  = (state_reg == S_R);
  assign inst_valid  = (state_reg == S_OUT);
  assign inst        = inst_reg;
  assign fetch_err   = err_reg;
  assign err_cause   = cause_reg;

endmodule

// File: tb/tb_ysyx_23060111_ifu_hs.sv
// Self-checking bench for the handshaked fetch unit: directed scenarios plus
// randomized wait/data/redirect traffic checked against a transaction model.
module tb_ysyx_23060111_ifu_hs;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic        npc_valid;
  logic [31:0] npc;
  logic        fetch_err;
  logic [1:0]  err_cause;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_23060111_ifu_hs #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .mem_rready(mem_rready), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .npc_valid(npc_valid), .npc(npc),
    .fetch_err(fetch_err), .err_cause(err_cause)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rresp = 2'b00;
    inst_ready = 1'b0; npc_valid = 1'b0; npc = 32'h0;
  endtask

  // Holds rst for two edges, checks reset values, releases, and steps into AR.
  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    chk("rst_pc", pc, RST_PC);
    chk("rst_arvalid", 32'(mem_arvalid), 0);
    chk("rst_rready", 32'(mem_rready), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_inst", inst, 0);
    chk("rst_fetch_err", 32'(fetch_err), 0);
    chk("rst_err_cause", 32'(err_cause), 0);
    rst = 1'b0;
    chk("first_cycle_arvalid", 32'(mem_arvalid), 0);
    tick();
  endtask

  // One full instruction transaction, entered with the DUT expected in AR.
  task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] data,
                          input int arw, input int rw, input int ow, input int nw,
                          input logic [31:0] nxt);
    for (int i = 0; i <= arw; i++) begin
      chk("ar_arvalid", 32'(mem_arvalid), 1);
      chk("ar_araddr", mem_araddr, exp_pc);
      chk("ar_rready", 32'(mem_rready), 0);
      mem_arready = (i == arw);
      // Data offered during the AR handshake must be ignored.
      mem_rvalid  = (i == arw) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata   = $urandom;
      mem_rresp   = 2'b00;
      tick();
    end
    mem_arready = 1'b0;
    for (int i = 0; i <= rw; i++) begin
      chk("r_rready", 32'(mem_rready), 1);
      chk("r_arvalid", 32'(mem_arvalid), 0);
      chk("r_inst_valid", 32'(inst_valid), 0);
      mem_rvalid = (i == rw);
      mem_rdata  = (i == rw) ? data : $urandom;
      mem_rresp  = 2'b00;
      tick();
    end
    mem_rvalid = 1'b0;
    for (int i = 0; i <= ow; i++) begin
      chk("out_inst_valid", 32'(inst_valid), 1);
      chk("out_inst", inst, data);
      chk("out_rready", 32'(mem_rready), 0);
      inst_ready = (i == ow);
      npc_valid  = 1'($urandom_range(0, 1));
      npc        = $urandom;
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      tick();
    end
    inst_ready = 1'b0;
    mem_rvalid = 1'b0;
    for (int i = 0; i <= nw; i++) begin
      chk("wnpc_inst_valid", 32'(inst_valid), 0);
      chk("wnpc_arvalid", 32'(mem_arvalid), 0);
      chk("wnpc_pc", pc, exp_pc);
      npc_valid = (i == nw);
      npc       = (i == nw) ? nxt : $urandom;
      tick();
    end
    npc_valid = 1'b0;
  endtask

  // Random traffic while in ERR: nothing may move.
  task automatic err_hold(input int n, input logic [31:0] exp_pc, input logic [1:0] cause,
                          input logic [31:0] exp_inst);
    for (int i = 0; i < n; i++) begin
      mem_arready = 1'($urandom_range(0, 1));
      mem_rvalid  = 1'($urandom_range(0, 1));
      mem_rresp   = 2'($urandom_range(0, 3));
      mem_rdata   = $urandom;
      inst_ready  = 1'($urandom_range(0, 1));
      npc_valid   = 1'($urandom_range(0, 1));
      npc         = $urandom;
      tick();
      chk("err_arvalid", 32'(mem_arvalid), 0);
      chk("err_rready", 32'(mem_rready), 0);
      chk("err_inst_valid", 32'(inst_valid), 0);
      chk("err_pc", pc, exp_pc);
      chk("err_inst", inst, exp_inst);
      chk("err_flag", 32'(fetch_err), 1);
      chk("err_cause", 32'(err_cause), 32'(cause));
    end
    idle_inputs();
  endtask

  initial begin
    logic [31:0] pc_model;
    logic [31:0] nxt;
    logic [31:0] data;

    do_reset();

    // Zero-wait loop, then backpressure on every channel.
    do_fetch(RST_PC, 32'h0010_0093, 0, 0, 0, 0, 32'h8000_0004);
    do_fetch(32'h8000_0004, 32'hDEAD_BEEF, 3, 2, 5, 2, 32'h8000_0100);

    // Randomized traffic against a PC/data transaction model.
    pc_model = 32'h8000_0100;
    for (int n = 0; n < 24; n++) begin
      data = $urandom;
      nxt  = $urandom & 32'hFFFF_FFFC;
      if (n == 10) nxt = 32'hFFFF_FFFC;
      if (n == 11) nxt = 32'h0000_0000;
      do_fetch(pc_model, data, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), nxt);
      pc_model = nxt;
    end

    // Bus error during the data phase.
    chk("be_arvalid", 32'(mem_arvalid), 1);
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rresp   = 2'b10;
    mem_rdata   = 32'h1234_5678;
    tick();
    idle_inputs();
    chk("be_fetch_err", 32'(fetch_err), 1);
    chk("be_err_cause", 32'(err_cause), 32'd1);
    chk("be_inst_kept", inst, data);
    err_hold(20, pc_model, 2'b01, data);

    do_reset();

    // Misaligned redirect.
    do_fetch(RST_PC, 32'h0000_0013, 1, 1, 1, 1, 32'h8000_0102);
    chk("mis_fetch_err", 32'(fetch_err), 1);
    chk("mis_err_cause", 32'(err_cause), 32'd2);
    chk("mis_pc", pc, RST_PC);
    err_hold(6, RST_PC, 2'b10, 32'h0000_0013);

    do_reset();
    do_fetch(RST_PC, 32'h0000_0513, 0, 0, 0, 0, 32'h8000_0100);
    do_fetch(32'h8000_0100, 32'h0040_0113, 0, 1, 0, 0, 32'h8000_0104);

    // Reset while R is waiting on data, then a late rvalid.
    do_reset();
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    chk("mid_rready", 32'(mem_rready), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_rready", 32'(mem_rready), 0);
    chk("mid_rst_arvalid", 32'(mem_arvalid), 0);
    chk("mid_rst_inst_valid", 32'(inst_valid), 0);
    chk("mid_rst_pc", pc, RST_PC);
    chk("mid_rst_inst", inst, 0);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    tick();
    mem_rvalid = 1'b0;
    do_fetch(RST_PC, 32'h0030_0193, 0, 0, 0, 0, 32'h8000_0008);
    chk("mid_next_araddr", mem_araddr, 32'h8000_0008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
